rom_loader: RTL

//  Boot-time reader for the byte-wide program ROM (combinational: address in, byte + last-byte flag out).

---
 rtl/rom_loader_pkg.sv | 24 ++
 rtl/rom_loader_byte_lane_packer.sv | 34 +++
 rtl/rom_loader.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/rom_loader_pkg.sv
// Shared types and widths for the boot ROM loader.
package rom_loader_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = LANES * BYTE_W;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LANE_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
        logic [LANES-1:0]  strb;
    } mem_wr_t;

endpackage

// File: rtl/rom_loader_byte_lane_packer.sv
// Lane-register storage: collects ROM bytes into their lanes and tracks which lanes are filled.
module byte_lane_packer
    import rom_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              load,
    input  logic [LANE_W-1:0] lane,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic [LANES-1:0]  strb
);

    logic [LANES-1:0][BYTE_W-1:0] lanes_q;
    logic [LANES-1:0]             strb_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lanes_q <= '0;
            strb_q  <= '0;
        end else if (clear) begin
            lanes_q <= '0;
            strb_q  <= '0;
        end else if (load) begin
            lanes_q[lane] <= byte_in;
            strb_q[lane]  <= 1'b1;
        end
    end

    assign word = lanes_q;
    assign strb = strb_q;

endmodule

// File: rtl/rom_loader.sv
// Boot loader: walks the byte-wide ROM from address 0 and writes little-endian packed words to memory.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] MEM_BASE  = 32'h0000_0000,
    parameter int unsigned       MAX_BYTES = 65536
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [BYTE_W-1:0] rom_byte,
    input  logic              rom_done,
    output logic              mem_wr_valid,
    input  logic              mem_wr_ready,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [WORD_W-1:0] mem_wr_data,
    output logic [LANES-1:0]  mem_wr_strb,
    output logic              busy,
    output logic              boot_done,
    output logic              error
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       cnt_q, cnt_d, cnt_next;
    mem_wr_t           wr_q, wr_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              pk_clear_c, pk_load_c;
    logic [LANE_W-1:0] lane_c;
    logic [WORD_W-1:0] pk_word, merged_data_c;
    logic [LANES-1:0]  pk_strb, merged_strb_c;

    byte_lane_packer u_packer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (pk_clear_c),
        .load    (pk_load_c),
        .lane    (lane_c),
        .byte_in (rom_byte),
        .word    (pk_word),
        .strb    (pk_strb)
    );

    // Word as it will look once the byte presented this cycle is folded in.
    assign lane_c        = addr_q[LANE_W-1:0];
    assign merged_data_c = pk_word | (WORD_W'(rom_byte) << {lane_c, 3'b000});
    assign merged_strb_c = pk_strb | (LANES'(1) << lane_c);
    assign cnt_next      = cnt_q + 32'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            wr_q    <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        valid_d    = valid_q;
        last_d     = last_q;
        done_d     = done_q;
        err_d      = err_q;
        pk_clear_c = 1'b0;
        pk_load_c  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d    = ST_FETCH;
                    addr_d     = '0;
                    cnt_d      = '0;
                    last_d     = 1'b0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    pk_clear_c = 1'b1;
                end
            end
            ST_FETCH: begin
                pk_load_c = 1'b1;
                cnt_d     = cnt_next;
                // Runaway guard wins over a full-word write: no partial write on abort.
                if (!rom_done && (cnt_next >= 32'(MAX_BYTES))) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end else if (rom_done || (lane_c == LANE_W'(LANES - 1))) begin
                    wr_d.addr = MEM_BASE + {addr_q[ADDR_W-1:LANE_W], LANE_W'(0)};
                    wr_d.data = merged_data_c;
                    wr_d.strb = merged_strb_c;
                    valid_d   = 1'b1;
                    last_d    = rom_done;
                    state_d   = ST_WRITE;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            ST_WRITE: begin
                if (mem_wr_ready) begin
                    valid_d    = 1'b0;
                    pk_clear_c = 1'b1;
                    if (last_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_FETCH) || (state_d == ST_WRITE);
    end

    assign rom_address  = addr_q;
    assign mem_wr_valid = valid_q;
    assign mem_wr_addr  = wr_q.addr;
    assign mem_wr_data  = wr_q.data;
    assign mem_wr_strb  = wr_q.strb;
    assign busy         = busy_q;
    assign boot_done    = done_q;
    assign error        = err_q;

endmodule
